// File: rtl/rv_decode_pkg.sv
// Shared RISC-V decode definitions: opcode constants, immediate format enum,
// decoded field struct and small opcode classification helpers.
package rv_decode_pkg;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;

  typedef struct packed {
    logic [4:0] opcode;
    logic [2:0] func3;
    logic       func7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } dec_fields_t;

  function automatic imm_type_e imm_type_of(input logic [4:0] opc);
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: return IMM_I;
      OPC_STORE:                      return IMM_S;
      OPC_BRANCH:                     return IMM_B;
      OPC_LUI, OPC_AUIPC:             return IMM_U;
      OPC_JAL:                        return IMM_J;
      default:                        return IMM_NONE;
    endcase
  endfunction

  function automatic logic opcode_legal(input logic [4:0] opc);
    case (opc)
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: return 1'b1;
      default:                                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational immediate generator: picks the format from inst[6:2] and
// sign-extends from inst[31] to XLEN.
module rv_imm_gen
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;
  logic        unused_low_bits;

  assign unused_low_bits = ^inst[1:0];

  always_comb begin
    imm32 = '0;
    unique case (imm_type_of(inst[6:2]))
      IMM_I:    imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_S:    imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:    imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:    imm32 = {inst[31:12], 12'b0};
      IMM_J:    imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:  imm32 = '0;
    endcase
  end

  // Every 32-bit form already carries inst[31] in its top bit.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_decode_stage.sv
// Registered RISC-V decode stage with a two-entry (main + skid) buffer.
// Define ILLEGAL_CHK_EN to add the registered out_illegal flag.
module id_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_opcode,
  output logic [2:0]      out_func3,
  output logic            out_func7,
  output logic [4:0]      out_rs1_index,
  output logic [4:0]      out_rs2_index,
  output logic [4:0]      out_rd_index,
  output logic [XLEN-1:0] out_imm
`ifdef ILLEGAL_CHK_EN
  ,
  output logic            out_illegal
`endif
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    dec_fields_t     f;
    logic [XLEN-1:0] imm;
`ifdef ILLEGAL_CHK_EN
    logic            illegal;
`endif
  } dec_bundle_t;

  dec_bundle_t     dec;
  dec_bundle_t     main_q;
  dec_bundle_t     skid_q;
  logic            main_valid;
  logic            skid_valid;
  logic [XLEN-1:0] imm;
  logic            accept;
  logic            handoff;

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (in_inst),
    .imm  (imm)
  );

  always_comb begin
    dec          = '0;
    dec.pc       = in_pc;
    dec.f.opcode = in_inst[6:2];
    dec.f.func3  = in_inst[14:12];
    dec.f.func7  = in_inst[30];
    dec.f.rs1    = in_inst[19:15];
    dec.f.rs2    = in_inst[24:20];
    dec.f.rd     = in_inst[11:7];
    dec.imm      = imm;
`ifdef ILLEGAL_CHK_EN
    dec.illegal  = (in_inst[1:0] != 2'b11) || !opcode_legal(in_inst[6:2]);
`endif
  end

  // Valid/ready: a transfer happens on a rising edge where both valid and
  // ready are 1; valid never depends on ready, and in_ready is a pure register.
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign handoff  = main_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || handoff) begin
      // Skid is older than anything offered now, so it refills main first.
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept;
        if (accept) main_q <= dec;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid     = main_valid;
  assign out_pc        = main_q.pc;
  assign out_opcode    = main_q.f.opcode;
  assign out_func3     = main_q.f.func3;
  assign out_func7     = main_q.f.func7;
  assign out_rs1_index = main_q.f.rs1;
  assign out_rs2_index = main_q.f.rs2;
  assign out_rd_index  = main_q.f.rd;
  assign out_imm       = main_q.imm;
`ifdef ILLEGAL_CHK_EN
  assign out_illegal   = main_q.illegal;
`endif

endmodule

// File: doc/id_decode_stage.md
# id_decode_stage

Registered RISC-V instruction decode stage between fetch and register read. Each accepted instruction word is split into opcode, func3, func7 bit and register indices, and the sign-extended immediate is generated for its format. Results are held in a two-entry skid buffer with valid/ready handshakes on both sides, so backpressure from execute never drops an instruction. A synchronous flush squashes everything in flight on a taken branch or jump.

## Interface
Parameters:
- XLEN, 32: datapath width for `pc` and `imm`; legal values are 32 and 64.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept an instruction.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  PC of `in_inst`.
- flush  in  1  synchronous squash of all held and incoming instructions.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  downstream accepts the decoded instruction.
- out_pc  out  XLEN  PC of the presented instruction.
- out_opcode  out  5  `inst[6:2]`.
- out_func3  out  3  `inst[14:12]`.
- out_func7  out  1  `inst[30]`.
- out_rs1_index, out_rs2_index, out_rd_index  out  5 each  `inst[19:15]`, `inst[24:20]`, `inst[11:7]`.
- out_imm  out  XLEN  sign-extended immediate.
- out_illegal  out  1  illegal-instruction flag; this port exists only with ILLEGAL_CHK_EN.

## Operation
- Decode is combinational on `in_inst`. The decoded bundle is what gets stored: pc, fields, imm and illegal.
- Immediate format is selected by opcode[6:2]:
  - I-type: 00000, 00100, 11001.
  - S-type: 01000.
  - B-type: 11000. Bit 0 is 0.
  - U-type: 01101, 00101. `{inst[31:12], 12'b0}`, then sign-extended.
  - J-type: 11011. Bit 0 is 0.
  - Any other opcode: imm = 0.
  - Sign bit is always `inst[31]`, extended to XLEN.
- Storage is a main entry and a skid entry, each with its own valid bit. `out_*` is driven from the main entry.
- `in_ready` is `!skid_valid`. It is derived from a register only, with no combinational path from `out_ready`.
- Accept happens when `in_valid & in_ready`. Handoff happens when `out_valid & out_ready`.
- Per-cycle rules, when not flushing:
  - Main empty, or handoff this cycle: the main entry takes the skid entry if it is valid, otherwise the accepted input.
  - Main stalled (valid and no handoff) and accept occurs: the input goes to skid.
  - Skid valid and handoff: skid moves to main, and skid becomes empty. If skid is valid, `in_ready` is 0, so there is never a simultaneous accept.
- Order is strictly preserved. The stage never holds more than 2 instructions.
- Flush:
  - Next edge: main_valid = 0 and skid_valid = 0.
  - An input offered in the flush cycle is dropped, even though the handshake completes if `in_ready` was 1.
  - A handoff in the flush cycle still counts as consumed.
- Data registers update only on load, so `out_*` holds stable while out_valid is 1 and out_ready is 0.

## Timing
- Reset (asynchronous): both valids go to 0, all data registers go to 0 and out_illegal goes to 0. in_ready reads 1 during and after reset.
- Latency: accept at edge N gives out_valid = 1 after edge N.
- Throughput: 1 instruction per cycle while out_ready is 1.
- Stall: one extra accept is absorbed into skid, and in_ready is 0 from the next cycle.
- After out_ready returns, in_ready is 1 one cycle later.
- Reset deasserting mid-transfer: the stage restarts empty. No state survives reset.

## Configuration
- ILLEGAL_CHK_EN defined:
  - out_illegal is present, registered with the bundle.
  - It is set when `inst[1:0] != 2'b11`, or when the opcode is not one of 00000, 00011, 00100, 00101, 01000, 01100, 01101, 11000, 11001, 11011, 11100.
  - An illegal instruction still flows and is decoded normally. Only the flag is added.
- ILLEGAL_CHK_EN undefined: there is no out_illegal port and no check logic.

## Structure
- Shared package `rv_decode_pkg` holds:
  - opcode constants (OPC_LOAD, OPC_OP_IMM, …);
  - enum `imm_type_e` {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE};
  - packed struct `dec_bundle_t`, parameterised by XLEN through the module.
- One sub-module `rv_imm_gen` (XLEN parameter) is natural. Input is inst and output is imm; it is combinational.
- Buffer control stays in `id_decode_stage`.

## Test plan
- Reset, then a single transfer:
  - After reset: in_ready = 1, out_valid = 0, outputs all 0.
  - Accept inst 0xFE010113 (addi sp,sp,-32) at pc 0x100.
  - Next cycle: out_opcode = 00100, rd = 2, rs1 = 2, out_imm = 0xFFFFFFE0.
- Immediate formats, XLEN = 64:
  - sw 0x00112623 gives imm 12.
  - beq 0xFE000EE3 gives imm −4 (0xFFFFFFFFFFFFFFFC).
  - lui 0x800002B7 gives imm 0xFFFFFFFF80000000.
  - jal 0x7FFFF06F gives imm 0x000FFFFE.
  - add 0x00B50533 gives imm 0.
- Backpressure:
  - Hold out_ready = 0 and stream 3 instructions A, B, C.
  - A sits in main and B in skid. in_ready drops, and C stalls with in_valid held.
  - Release out_ready: the bench sees A, B, C in order with no loss or duplicate.
- Flush with a full buffer:
  - Assert flush with both entries valid and in_valid = 1.
  - Next cycle: out_valid = 0 and in_ready = 1. The offered instruction never appears.
- Full-rate stream:
  - With out_ready = 1, send 100 back-to-back instructions.
  - in_ready stays 1 throughout. Output is 1/cycle and order is preserved.
- With ILLEGAL_CHK_EN:
  - 0x00000000 (inst[1:0] = 00) sets out_illegal = 1.
  - Opcode 0x57 (vector, 10101) sets out_illegal = 1.
  - 0x00000073 (ecall) gives out_illegal = 0.
